// File: rtl/cmd_ram_burst.sv
// cmd_ram_burst: command-decoded single-port RAM with address auto-increment and back-pressured burst reads
module cmd_ram_burst #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 8,
  parameter int AUTO_INC = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W+1:0] din,
  input  logic              rx_valid,
  input  logic              tx_ready,
  output logic [DATA_W-1:0] dout,
  output logic              tx_valid,
  output logic              busy,
  output logic              err
);
  typedef enum logic [1:0] {IDLE, FETCH, VALID} state_t;
  localparam logic [ADDR_W-1:0] INC = ADDR_W'(AUTO_INC != 0);
  state_t            state;
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] count;
  logic [1:0]        cmd;
  logic [DATA_W-1:0] payload;
  logic              accept;
  assign cmd     = din[DATA_W+1:DATA_W];
  assign payload = din[DATA_W-1:0];
  assign accept  = rx_valid && state == IDLE;
  // storage array carries no reset so it can map onto a block RAM
  always_ff @(posedge clk)
    if (rst_n && accept && cmd == 2'b01) mem[wr_addr] <= payload;
  // command decode, burst sequencing and registered status outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      dout     <= '0;
      tx_valid <= 1'b0;
      busy     <= 1'b0;
      err      <= 1'b0;
      wr_addr  <= '0;
      rd_addr  <= '0;
      count    <= '0;
    end else begin
      err <= rx_valid && state != IDLE;
      case (state)
        IDLE:
          if (rx_valid)
            case (cmd)
              2'b00: wr_addr <= payload[ADDR_W-1:0];
              2'b01: wr_addr <= wr_addr + INC;
              2'b10: rd_addr <= payload[ADDR_W-1:0];
              default: begin
                count <= payload == '0 ? DATA_W'(1) : payload;
                busy  <= 1'b1;
                state <= FETCH;
              end
            endcase
        FETCH: begin
          dout     <= mem[rd_addr];
          tx_valid <= 1'b1;
          state    <= VALID;
        end
        VALID:
          if (tx_ready) begin
            count    <= count - DATA_W'(1);
            rd_addr  <= rd_addr + INC;
            tx_valid <= 1'b0;
            busy     <= count != DATA_W'(1);
            state    <= count == DATA_W'(1) ? IDLE : FETCH;
          end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cmd_ram_burst.sv
// tb_cmd_ram_burst: randomized and directed checks of cmd_ram_burst against a timeline reference model
module tb_cmd_ram_burst;
  logic        clk = 0, rst_n = 0, rx_valid = 0, tx_ready = 0;
  logic [9:0]  din = '0;
  logic [7:0]  dout;
  logic        tx_valid, busy, err;
  logic        rx2 = 0, rdy2 = 1;
  logic [17:0] din2 = '0;
  logic [15:0] dout2;
  logic        tv2, busy2, err2;
  int total = 0, bad = 0;
  // reference model: memory image, address pointers and burst timeline
  logic [7:0] mem_m [256];
  logic [7:0] wa = 0, ra = 0, m_dout = 0;
  bit   idle = 1, m_err = 0;
  int   left = 0, vt = 0, k = 0;
  int   q[$];
  int   q2[$];
  int   nerr;
  cmd_ram_burst dut (.clk(clk), .rst_n(rst_n), .din(din), .rx_valid(rx_valid), .tx_ready(tx_ready),
    .dout(dout), .tx_valid(tx_valid), .busy(busy), .err(err));
  cmd_ram_burst #(.DATA_W(16), .ADDR_W(10), .AUTO_INC(0)) dut2 (.clk(clk), .rst_n(rst_n), .din(din2),
    .rx_valid(rx2), .tx_ready(rdy2), .dout(dout2), .tx_valid(tv2), .busy(busy2), .err(err2));
  always #5 clk = ~clk;
  task automatic chk(string tag, int got, int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // one clock of stimulus on the default instance, model update, then output comparison
  task automatic step(bit rx, logic [1:0] c, logic [7:0] p, bit rdy, bit rs = 1);
    bit vb;
    rx_valid = rx; din = {c, p}; tx_ready = rdy; rst_n = rs;
    k++;
    vb = !idle && (k - 1 >= vt);
    if (vb && rdy && rs) q.push_back(int'(dout));
    if (!rs) begin
      idle = 1; m_dout = 0; wa = 0; ra = 0; m_err = 0;
    end else begin
      if (!idle && k == vt) m_dout = mem_m[ra];
      m_err = rx && !idle;
      if (idle && rx)
        case (c)
          2'd0: wa = p;
          2'd1: begin mem_m[wa] = p; wa++; end
          2'd2: ra = p;
          default: begin idle = 0; left = (p == 0) ? 1 : int'(p); vt = k + 1; end
        endcase
      else if (vb && rdy) begin
        left--; ra++;
        if (left == 0) idle = 1; else vt = k + 1;
      end
    end
    @(posedge clk); #1;
    rx_valid = 0; rst_n = 1;
    if (err) nerr++;
    chk("busy", int'(busy), int'(!idle));
    chk("tx_valid", int'(tx_valid), int'(!idle && k >= vt));
    chk("dout", int'(dout), int'(m_dout));
    chk("err", int'(err), int'(m_err));
  endtask
  task automatic step2(bit rx, logic [1:0] c, logic [15:0] p);
    rx2 = rx; din2 = {c, p};
    if (tv2) q2.push_back(int'(dout2));
    @(posedge clk); #1;
    rx2 = 0;
  endtask
  initial begin
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 1);
    for (int i = 0; i < 256; i++) step(1, 1, 8'(i) ^ 8'h5A, 1);
    q.delete();
    step(1, 0, 8'h10, 1); step(1, 1, 8'hA5, 1); step(1, 2, 8'h10, 1); step(1, 3, 8'h00, 1);
    repeat (4) step(0, 0, 0, 1);
    chk("single_n", q.size(), 1);
    chk("single_d", q[0], 'hA5);
    q.delete();
    step(1, 0, 8'hFE, 1); step(1, 1, 8'h11, 1); step(1, 1, 8'h22, 1); step(1, 1, 8'h33, 1);
    step(1, 2, 8'hFE, 1); step(1, 3, 8'h03, 1);
    repeat (7) step(0, 0, 0, 1);
    step(1, 3, 8'h01, 1);
    repeat (3) step(0, 0, 0, 1);
    chk("wrap_n", q.size(), 4);
    chk("wrap_0", q[0], 'h11);
    chk("wrap_1", q[1], 'h22);
    chk("wrap_2", q[2], 'h33);
    chk("wrap_ra", q[3], 'h5B);
    q.delete();
    step(1, 3, 8'h02, 0);
    repeat (6) step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    repeat (4) step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    repeat (3) step(0, 0, 0, 1);
    chk("bp_n", q.size(), 2);
    q.delete();
    nerr = 0;
    step(1, 0, 8'h20, 1); step(1, 3, 8'h03, 1); step(1, 0, 8'h40, 1);
    for (int i = 0; i < 20; i++) step(!idle && left == 1 && k >= vt, 0, 8'h40, 1);
    chk("drop_err", nerr, 2);
    step(1, 1, 8'h77, 1); step(1, 2, 8'h20, 1); step(1, 3, 8'h01, 1);
    repeat (3) step(0, 0, 0, 1);
    chk("drop_wa", q[q.size() - 1], 'h77);
    step(1, 3, 8'h02, 0); step(0, 0, 0, 0); step(0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("rst_dout", int'(dout), 0);
    step(1, 2, 8'h20, 1); step(1, 3, 8'h00, 1);
    repeat (3) step(0, 0, 0, 1);
    chk("rst_mem", q[q.size() - 1], 'h77);
    for (int i = 0; i < 3000; i++) begin
      logic [1:0] c;
      logic [7:0] p;
      c = 2'($urandom_range(0, 3));
      p = (c == 3) ? 8'($urandom_range(0, 4)) : 8'($urandom);
      step($urandom_range(0, 2) == 0, c, p, $urandom_range(0, 3) != 0, $urandom_range(0, 299) != 0);
    end
    step2(1, 0, 16'h03FF); step2(1, 1, 16'hBEEF); step2(1, 1, 16'hCAFE);
    step2(1, 2, 16'h03FF); step2(1, 3, 16'h0002);
    repeat (8) step2(0, 0, 0);
    chk("p_n", q2.size(), 2);
    chk("p_0", q2[0], 'hCAFE);
    chk("p_1", q2[1], 'hCAFE);
    chk("p_err", int'(err2), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cmd_ram_burst.md
Name: cmd_ram_burst

Overview:
Parametrised, command-driven single-port RAM that sits behind the SPI slave.
- Decodes {cmd, payload} words from the slave's receive path: set write address, write data, set read address, read.
- Generalises the 8-bit/256-entry RAM in data and address width.
- Adds optional address auto-increment, multi-word burst reads with tx_ready back-pressure, a busy flag and a dropped-command error pulse.

Parameters:
- DATA_W, 8, width of data words and of the command payload; must satisfy DATA_W >= ADDR_W.
- ADDR_W, 8, address width; memory depth is 2**ADDR_W words.
- AUTO_INC, 1, when 1 the write address increments after each data write and the read address after each delivered read word; when 0 addresses are static.

Ports:
- clk  input  1  clock; all logic on its rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- din  input  DATA_W+2  din[DATA_W+1:DATA_W] = cmd, din[DATA_W-1:0] = payload.
- rx_valid  input  1  din valid this cycle; single-cycle qualifier per command.
- tx_ready  input  1  downstream (SPI slave) accepts dout this cycle.
- dout  output  DATA_W  read data.
- tx_valid  output  1  dout valid; held until accepted.
- busy  output  1  burst read in progress; commands are not accepted.
- err  output  1  one-cycle pulse when a command is dropped.

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE, dout=0, tx_valid=0, busy=0, err=0, wr_addr=0, rd_addr=0, count=0. Memory contents are not cleared. Reset applies in any state, including mid-burst.
- Accept rule: a command is accepted when rx_valid=1 and state=IDLE. Only accepted commands change state.
- rx_valid=1 while state!=IDLE: the command is dropped, and err=1 on the next cycle for one cycle. This includes the cycle of the final burst handshake.
- cmd 00: wr_addr <= payload[ADDR_W-1:0].
- cmd 01: mem[wr_addr] <= payload.
  - If AUTO_INC=1: wr_addr <= wr_addr+1, modulo 2**ADDR_W, so 2**ADDR_W-1 wraps to 0.
- cmd 10: rd_addr <= payload[ADDR_W-1:0].
- cmd 11: count <= payload, with payload 0 treated as 1. Go to FETCH.
- FSM states: IDLE, FETCH, VALID.
  - IDLE: busy=0, tx_valid=0. Accepting cmd 11 moves to FETCH.
  - FETCH, one cycle: dout <= mem[rd_addr]; move to VALID. busy=1.
  - VALID: tx_valid=1; dout holds stable.
  - VALID with tx_ready=1 (handshake): count <= count-1; if AUTO_INC=1, rd_addr <= rd_addr+1 (wraps).
    - If count==1: move to IDLE; tx_valid=0 and busy=0 next cycle.
    - Otherwise: move to FETCH.
  - VALID with tx_ready=0: stay; dout and tx_valid unchanged.
- Latency: cmd 11 accepted at cycle T gives busy=1 at T+1 and tx_valid=1 with valid dout at T+2. Each subsequent word arrives 2 cycles after the previous handshake.
- tx_ready while not in VALID is ignored.
- Writes cannot overlap a burst, because commands are dropped while busy.
- dout keeps its last value after a burst until the next FETCH.
- busy, tx_valid and err are registered outputs.
- Width rule: payload bits above ADDR_W-1 are ignored for address commands. count is DATA_W bits, so the maximum burst is 2**DATA_W-1 words.

Test Plan:
- Single read: with tx_ready=1, send 00_10, 01_A5, 10_10, 11_00 -> tx_valid=1 for exactly one cycle at T+2 with dout=0xA5; busy high for 2 cycles.
- Burst with wrap: send 00_FE, 01_11, 01_22, 01_33, 10_FE, 11_03 with tx_ready=1 -> dout sequence 0x11, 0x22, 0x33 (addresses FE, FF, 00), one word every 2 cycles; busy=0 after the third handshake; rd_addr=0x01.
- Back-pressure: burst 11_02 with tx_ready held 0 for 5 cycles in VALID -> tx_valid=1 and dout stable for all 5 cycles; advances only on tx_ready=1; exactly 2 words delivered.
- Dropped command: send 00_40 during a burst -> err=1 for one cycle; wr_addr unchanged. Also send a command in the same cycle as the final handshake -> also dropped with err.
- Reset mid-burst: rst_n=0 for one cycle in VALID -> dout=0, tx_valid=0, busy=0, state IDLE. A subsequent read of an address written before the reset returns its data.
- Parameter instance with AUTO_INC=0, DATA_W=16, ADDR_W=10:
  - 00_03FF, 01_BEEF, 01_CAFE -> mem[0x3FF]=0xCAFE.
  - 10_03FF, 11_0002 -> dout=0xCAFE twice.
